// File: rtl/ram_fifo.sv
// Single-clock FIFO over a dual-port RAM array.
// Registered read data, occupancy flags and error pulses.
module ram_fifo #(
  parameter int D_WIDTH  = 8,
  parameter int A_WIDTH  = 5,
  parameter int A_MAX    = 32,
  parameter int AF_LEVEL = 28,
  parameter int AE_LEVEL = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               write_enable,
  input  logic [D_WIDTH-1:0] data_write,
  input  logic               read_enable,
  output logic [D_WIDTH-1:0] data_read,
  output logic               read_valid,
  output logic [A_WIDTH:0]   level,
  output logic               full,
  output logic               empty,
  output logic               almost_full,
  output logic               almost_empty,
  output logic               overflow,
  output logic               underflow
);

  localparam logic [A_WIDTH:0] LV_MAX = (A_WIDTH+1)'(A_MAX);
  localparam logic [A_WIDTH:0] LV_AF  = (A_WIDTH+1)'(AF_LEVEL);
  localparam logic [A_WIDTH:0] LV_AE  = (A_WIDTH+1)'(AE_LEVEL);

  logic [D_WIDTH-1:0] mem [A_MAX];
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] rd_ptr;
  logic [A_WIDTH:0]   lvl_nxt;
  logic               wr_ok;
  logic               rd_ok;

  // A pop at full frees the slot the push lands in.
  assign rd_ok = read_enable && !empty;
  assign wr_ok = write_enable && (!full || read_enable);

  always_comb begin
    lvl_nxt = level;
    unique case ({wr_ok, rd_ok})
      2'b10:   lvl_nxt = level + 1'b1;
      2'b01:   lvl_nxt = level - 1'b1;
      default: lvl_nxt = level;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= data_write;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      data_read    <= '0;
      read_valid   <= 1'b0;
      level        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) begin
        data_read <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      read_valid   <= rd_ok;
      level        <= lvl_nxt;
      full         <= (lvl_nxt == LV_MAX);
      empty        <= (lvl_nxt == '0);
      almost_full  <= (lvl_nxt >= LV_AF);
      almost_empty <= (lvl_nxt <= LV_AE);
      overflow     <= write_enable && !wr_ok;
      underflow    <= read_enable && !rd_ok;
    end
  end

endmodule

// File: tb/tb_ram_fifo.sv
// Directed bench for ram_fifo with a queue scoreboard.
// Every output is checked against a reference model each cycle.
module tb_ram_fifo;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       write_enable;
  logic [7:0] data_write;
  logic       read_enable;
  logic [7:0] data_read;
  logic       read_valid;
  logic [5:0] level;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int total = 0;
  int bad = 0;

  logic [7:0] q[$];
  logic [7:0] last_d = 8'h00;

  ram_fifo dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .write_enable (write_enable),
    .data_write   (data_write),
    .read_enable  (read_enable),
    .data_read    (data_read),
    .read_valid   (read_valid),
    .level        (level),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic rv,
                         input logic ov,
                         input logic uf);
    int n;
    n = q.size();
    chk({tag, ":level"}, 32'(level), 32'(n));
    chk({tag, ":full"}, 32'(full), 32'(n == 32));
    chk({tag, ":empty"}, 32'(empty), 32'(n == 0));
    chk({tag, ":af"}, 32'(almost_full), 32'(n >= 28));
    chk({tag, ":ae"}, 32'(almost_empty), 32'(n <= 4));
    chk({tag, ":rv"}, 32'(read_valid), 32'(rv));
    chk({tag, ":data"}, 32'(data_read), 32'(last_d));
    chk({tag, ":ovf"}, 32'(overflow), 32'(ov));
    chk({tag, ":udf"}, 32'(underflow), 32'(uf));
  endtask

  task automatic step(input logic we,
                      input logic [7:0] wd,
                      input logic re,
                      input string tag);
    int  n;
    bit  rdm;
    bit  wrm;
    @(negedge clk);
    write_enable = we;
    data_write   = wd;
    read_enable  = re;
    n   = q.size();
    rdm = re && (n > 0);
    wrm = we && ((n < 32) || re);
    if (rdm) last_d = q.pop_front();
    if (wrm) q.push_back(wd);
    @(posedge clk);
    #1;
    chk_all(tag, rdm, we && !wrm, re && !rdm);
  endtask

  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    write_enable = 1'b0;
    read_enable  = 1'b0;
    q.delete();
    last_d = 8'h00;
    #1;
    chk_all(tag, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n      = 1'b1;
    write_enable = 1'b0;
    data_write   = 8'h00;
    read_enable  = 1'b0;
    repeat (2) @(posedge clk);
    async_reset("reset");

    for (int i = 0; i < 32; i++)
      step(1'b1, 8'(i), 1'b0, $sformatf("fill%0d", i));
    step(1'b1, 8'hEE, 1'b0, "ovf");
    step(1'b0, 8'h00, 1'b0, "ovf_clr");

    step(1'b1, 8'hC5, 1'b1, "full_rw");

    for (int i = 0; i < 32; i++)
      step(1'b0, 8'h00, 1'b1, $sformatf("drain%0d", i));
    step(1'b0, 8'h00, 1'b1, "udf");
    step(1'b0, 8'h00, 1'b0, "udf_clr");

    step(1'b1, 8'h3C, 1'b1, "empty_rw");
    step(1'b0, 8'h00, 1'b1, "empty_rw_pop");

    for (int i = 0; i < 3; i++)
      step(1'b1, 8'(8'h40 + i), 1'b0, "prime");
    for (int i = 3; i < 103; i++)
      step(1'b1, 8'(8'h40 + i), 1'b1,
           $sformatf("stream%0d", i));

    for (int i = 0; i < 7; i++)
      step(1'b1, 8'(8'h90 + i), 1'b0, "to10");
    chk("lvl10", 32'(level), 32'd10);
    async_reset("midreset");

    step(1'b1, 8'hA5, 1'b0, "post_push");
    step(1'b0, 8'h00, 1'b1, "post_pop");
    chk("post_a5", 32'(data_read), 32'h0000_00A5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
